fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Front end of the 5-stage RV32 pipeline. Owns the PC and issues word requests to the instruction cache.
- Registers the fetched instruction into the F/D pipeline register (fd_pc, fd_instr) consumed by decode.
- Obeys decode's stall, branch_en and branch_PC, and memory's dcache_stall.
- Drives icache_stall so the downstream stages freeze while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUBBLE_INSTR, 32'h0000_0013, instruction word (addi x0,x0,0) placed in fd_instr on flush.

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  synchronous, active-high.
- stall  in  1  load-use stall from decode.
- branch_en  in  1  redirect request from decode.
- branch_PC  in  32  redirect target.
- dcache_stall  in  1  global freeze from memory stage.
- ic_req  out  1  fetch request valid.
- ic_addr  out  32  fetch address (word aligned).
- ic_rdata  in  32  instruction word, valid when ic_ready=1.
- ic_ready  in  1  request completes this cycle.
- icache_stall  out  1  fetch cannot deliver this cycle; freezes the downstream stages.
- fd_pc  out  32  PC of fd_instr.
- fd_instr  out  32  instruction to decode.
- fd_valid  out  1  fd_instr is a real fetched instruction (0 = bubble).

Behaviour:
- Reset (synchronous; wins over everything, including mid-miss):
  - pc=RESET_PC, state=BOOT, fd_pc=0, fd_instr=BUBBLE_INSTR, fd_valid=0.
  - rb_valid=0, ic_req=0, icache_stall=0.
  - An outstanding request is abandoned; dropping ic_req cancels it.
- States: BOOT, FETCH, MISS, HOLD. ic_addr=pc in all states.
- BOOT: ic_req=0; next state FETCH unconditionally (one idle cycle). First valid fd appears 2 cycles after reset deasserts, given a hit.
- FETCH, per-cycle priority:
  - 1. dcache_stall=1: ic_req=0; hold pc, fd_*, state.
  - 2. stall=1: ic_req=0; hold pc, fd_*. branch_en is ignored this cycle (stall has priority).
  - 3. branch_en=1: ic_req may be 1, but the result is discarded. fd_instr<=BUBBLE_INSTR, fd_valid<=0, fd_pc<=0, pc<=branch_PC. Redirect penalty is exactly 1 bubble.
  - 4. ic_ready=1: fd_pc<=pc, fd_instr<=ic_rdata, fd_valid<=1, pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - 5. ic_ready=0: icache_stall=1 combinationally this same cycle; next state MISS. fd_* held so decode never consumes an instruction twice.
- MISS:
  - ic_req=1 and ic_addr=pc held constant until completion.
  - icache_stall = !ic_ready.
  - ic_ready=1 with dcache_stall=0: same update as FETCH rule 4, unless branch_en=1 (then rule 3; returned word discarded, pc<=branch_PC). stall=1 on the completion cycle: capture into rb, go HOLD. Otherwise next state FETCH.
  - ic_ready=1 with dcache_stall=1: rb_data<=ic_rdata, rb_valid<=1, next state HOLD.
- HOLD:
  - ic_req=0; icache_stall=0.
  - On the first cycle with dcache_stall=0 and stall=0, deliver the buffered word: apply the FETCH rule 3/4 priority with rb_data in place of ic_rdata; rb_valid<=0; next state FETCH.
- Only one request outstanding at any time. ic_ready while ic_req=0 is ignored.
- All fd_* and pc are registers. ic_req and icache_stall are combinational from state and inputs.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched [31:0] and perf_miss_cycles [31:0], reset to 0, wrapping at 2^32.
  - perf_fetched increments on every fd_valid<=1 load.
  - perf_miss_cycles increments on every cycle with icache_stall=1.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset released, ic_ready tied 1, ic_rdata=address -> BOOT for 1 cycle, then fd_pc=0,4,8 with fd_valid=1 on consecutive cycles, and fd_instr==fd_pc.
- Miss at pc=0x8: ic_ready=0 for 3 cycles -> icache_stall=1 for 3 cycles, ic_addr=0x8 held, fd_pc stays 0x4; 4th cycle ic_ready=1 -> icache_stall=0, next fd_pc=0x8.
- branch_en=1, branch_PC=0x100 while pc=0x10 -> next fd_valid=0 with fd_instr=0x00000013; following cycle fd_pc=0x100.
- stall=1 and branch_en=1 with branch_PC=0x200 in the same cycle -> fd held, pc unchanged, ic_req=0, no redirect; stall drops with branch_en=0 -> sequential fetch resumes.
- In MISS, dcache_stall=1 and ic_ready pulses with ic_rdata=0xDEADBEEF -> fd unchanged during freeze; first cycle after dcache_stall drops, fd_instr=0xDEADBEEF, fd_valid=1, icache_stall=0.
- reset asserted during MISS at pc=0x40 -> next cycle ic_req=0, fd_valid=0, pc=RESET_PC; a late ic_ready is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end of the 5-stage RV32 pipeline.
//
// Owns the PC, issues one word request at a time to the instruction cache,
// and registers the returned word into the F/D pipeline register consumed
// by decode. Follows decode's stall/redirect and memory's global freeze,
// and raises icache_stall while a fetch is outstanding.
//
// Ports:
//   clock, reset       pipeline clock, synchronous active-high reset
//   stall              load-use stall from decode
//   branch_en/_PC      redirect request and target from decode
//   dcache_stall       global freeze from the memory stage
//   ic_req/ic_addr     fetch request valid / word address (always = pc)
//   ic_rdata/ic_ready  returned instruction word / completion strobe
//   icache_stall       fetch cannot deliver this cycle
//   fd_pc/fd_instr/fd_valid  F/D pipeline register
//
// Optional feature: define FETCH_PERF_CNT_EN to add the free-running
// counters perf_fetched and perf_miss_cycles (both wrap at 2^32).
//
// State table:
//   BOOT  | one idle cycle after reset, no request issued
//   FETCH | issue request at pc; a hit loads F/D in the same cycle
//   MISS  | request outstanding, ic_addr held until ic_ready
//   HOLD  | word returned while frozen; parked in rb until released

module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [31:0] branch_PC,
  input  logic        dcache_stall,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic [31:0] ic_rdata,
  input  logic        ic_ready,
  output logic        icache_stall,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_instr,
  output logic        fd_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_miss_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_MISS  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] rb_data_q, rb_data_d;
  logic        rb_valid_q, rb_valid_d;

  // Per-cycle actions decided by the state logic, applied once below.
  logic        load_word;
  logic [31:0] load_data;
  logic        redirect;
  logic        req_c;
  logic        stall_c;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fd_pc_d    = fd_pc_q;
    fd_instr_d = fd_instr_q;
    fd_valid_d = fd_valid_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = rb_valid_q;
    load_word  = 1'b0;
    load_data  = ic_rdata;
    redirect   = 1'b0;
    req_c      = 1'b0;
    stall_c    = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (dcache_stall || stall) begin
          // Frozen: no request, everything held. A branch under stall is
          // dropped; decode re-presents it once the stall clears.
        end else if (branch_en) begin
          // No request on a redirect cycle: the word would be discarded
          // anyway, and keeping ic_req low avoids leaving one outstanding.
          redirect = 1'b1;
        end else begin
          req_c = 1'b1;
          if (ic_ready) begin
            load_word = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = ST_MISS;
          end
        end
      end

      ST_MISS: begin
        req_c   = 1'b1;
        stall_c = !ic_ready;
        if (ic_ready) begin
          if (dcache_stall || stall) begin
            rb_data_d  = ic_rdata;
            rb_valid_d = 1'b1;
            state_d    = ST_HOLD;
          end else if (branch_en) begin
            redirect = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            load_word = 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end

      ST_HOLD: begin
        if (!rb_valid_q) begin
          state_d = ST_FETCH;
        end else if (!dcache_stall && !stall) begin
          rb_valid_d = 1'b0;
          state_d    = ST_FETCH;
          if (branch_en) begin
            redirect = 1'b1;
          end else begin
            load_word = 1'b1;
            load_data = rb_data_q;
          end
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (redirect) begin
      fd_pc_d    = 32'h0000_0000;
      fd_instr_d = BUBBLE_INSTR;
      fd_valid_d = 1'b0;
      pc_d       = branch_PC;
    end else if (load_word) begin
      fd_pc_d    = pc_q;
      fd_instr_d = load_data;
      fd_valid_d = 1'b1;
      pc_d       = pc_q + 32'd4;
    end
  end

  // While reset is high the request is dropped, which cancels any miss.
  assign ic_req       = req_c && !reset;
  assign icache_stall = stall_c && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      fd_pc_q    <= 32'h0000_0000;
      fd_instr_q <= BUBBLE_INSTR;
      fd_valid_q <= 1'b0;
      rb_data_q  <= 32'h0000_0000;
      rb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fd_pc_q    <= fd_pc_d;
      fd_instr_q <= fd_instr_d;
      fd_valid_q <= fd_valid_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign ic_addr  = pc_q;
  assign fd_pc    = fd_pc_q;
  assign fd_instr = fd_instr_q;
  assign fd_valid = fd_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_miss_cycles_q, perf_miss_cycles_d;

  always_comb begin
    perf_fetched_d     = perf_fetched_q;
    perf_miss_cycles_d = perf_miss_cycles_q;
    if (load_word && !redirect) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (icache_stall) begin
      perf_miss_cycles_d = perf_miss_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched_q     <= 32'h0000_0000;
      perf_miss_cycles_q <= 32'h0000_0000;
    end else begin
      perf_fetched_q     <= perf_fetched_d;
      perf_miss_cycles_q <= perf_miss_cycles_d;
    end
  end

  assign perf_fetched     = perf_fetched_q;
  assign perf_miss_cycles = perf_miss_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. Each stimulus cycle pushes the
// hand-computed expected outputs for that cycle into a queue; a monitor
// on the falling edge pops one entry per cycle and compares.

module tb_fetch_stage;

  localparam logic [31:0] BB = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_en;
  logic [31:0] branch_PC;
  logic        dcache_stall;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_ready;
  logic        icache_stall;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;
  logic        fd_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_miss_cycles;
`endif

  // Instruction memory model: echoes the address, or returns a fixed word.
  logic        rd_echo;
  logic [31:0] rd_val;
  always_comb ic_rdata = rd_echo ? ic_addr : rd_val;

  always #5 clock = ~clock;

  fetch_stage dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_en    (branch_en),
    .branch_PC    (branch_PC),
    .dcache_stall (dcache_stall),
    .ic_req       (ic_req),
    .ic_addr      (ic_addr),
    .ic_rdata     (ic_rdata),
    .ic_ready     (ic_ready),
    .icache_stall (icache_stall),
    .fd_pc        (fd_pc),
    .fd_instr     (fd_instr),
    .fd_valid     (fd_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_miss_cycles (perf_miss_cycles)
`endif
  );

  typedef struct packed {
    logic [7:0]  id;
    logic        req;
    logic [31:0] addr;
    logic        ist;
    logic [31:0] fpc;
    logic [31:0] finstr;
    logic        fval;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  int   vec_id = 0;

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (ic_req !== e.req || ic_addr !== e.addr || icache_stall !== e.ist ||
          fd_pc !== e.fpc || fd_instr !== e.finstr || fd_valid !== e.fval) begin
        failed++;
        $display("FAIL vec%0d: got req=%b addr=%h ist=%b fd=%h/%h/%b, exp req=%b addr=%h ist=%b fd=%h/%h/%b",
                 e.id, ic_req, ic_addr, icache_stall, fd_pc, fd_instr, fd_valid,
                 e.req, e.addr, e.ist, e.fpc, e.finstr, e.fval);
      end
    end
  end

  task automatic cyc(
    input logic rst, input logic stl, input logic br, input logic [31:0] bpc,
    input logic dst, input logic rdy, input logic echo, input logic [31:0] rdv,
    input logic e_req, input logic [31:0] e_addr, input logic e_ist,
    input logic [31:0] e_fpc, input logic [31:0] e_finstr, input logic e_fval);
    exp_t e;
    reset        = rst;
    stall        = stl;
    branch_en    = br;
    branch_PC    = bpc;
    dcache_stall = dst;
    ic_ready     = rdy;
    rd_echo      = echo;
    rd_val       = rdv;
    e.id     = vec_id[7:0];
    e.req    = e_req;
    e.addr   = e_addr;
    e.ist    = e_ist;
    e.fpc    = e_fpc;
    e.finstr = e_finstr;
    e.fval   = e_fval;
    exp_q.push_back(e);
    vec_id++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_PC = '0;
    dcache_stall = 1'b0; ic_ready = 1'b0; rd_echo = 1'b1; rd_val = '0;
    repeat (2) @(posedge clock);
    #1;
    //  rst stl br bpc           dst rdy echo rdv            req addr          ist fd_pc         fd_instr      fd_valid
    cyc(1, 0, 0, 32'h0,         0, 1, 1, 32'h0,          0, 32'h0,         0, 32'h0,         BB,           0); // reset state
    // Boot and sequential hits
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          0, 32'h0,         0, 32'h0,         BB,           0); // BOOT
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h0,         0, 32'h0,         BB,           0);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h4,         0, 32'h0,         32'h0,        1);
    // Miss at 0x8 for 3 cycles
    cyc(0, 0, 0, 32'h0,         0, 0, 1, 32'h0,          1, 32'h8,         1, 32'h4,         32'h4,        1);
    cyc(0, 0, 0, 32'h0,         0, 0, 1, 32'h0,          1, 32'h8,         1, 32'h4,         32'h4,        1);
    cyc(0, 0, 0, 32'h0,         0, 0, 1, 32'h0,          1, 32'h8,         1, 32'h4,         32'h4,        1);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h8,         0, 32'h4,         32'h4,        1);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'hC,         0, 32'h8,         32'h8,        1);
    // Redirect to 0x100 at pc=0x10
    cyc(0, 0, 1, 32'h100,       0, 1, 1, 32'h0,          0, 32'h10,        0, 32'hC,         32'hC,        1);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h100,       0, 32'h0,         BB,           0);
    // stall beats branch
    cyc(0, 1, 1, 32'h200,       0, 1, 1, 32'h0,          0, 32'h104,       0, 32'h100,       32'h100,      1);
    cyc(0, 1, 1, 32'h200,       0, 1, 1, 32'h0,          0, 32'h104,       0, 32'h100,       32'h100,      1);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h104,       0, 32'h100,       32'h100,      1);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h108,       0, 32'h104,       32'h104,      1);
    // Miss completing under dcache_stall -> HOLD
    cyc(0, 0, 0, 32'h0,         0, 0, 1, 32'h0,          1, 32'h10C,       1, 32'h108,       32'h108,      1);
    cyc(0, 0, 0, 32'h0,         1, 0, 1, 32'h0,          1, 32'h10C,       1, 32'h108,       32'h108,      1);
    cyc(0, 0, 0, 32'h0,         1, 1, 0, 32'hDEADBEEF,   1, 32'h10C,       0, 32'h108,       32'h108,      1);
    cyc(0, 0, 0, 32'h0,         1, 0, 0, 32'h0,          0, 32'h10C,       0, 32'h108,       32'h108,      1);
    cyc(0, 0, 0, 32'h0,         0, 0, 0, 32'h0,          0, 32'h10C,       0, 32'h108,       32'h108,      1);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h110,       0, 32'h10C,       32'hDEADBEEF, 1);
    // dcache_stall in FETCH
    cyc(0, 0, 0, 32'h0,         1, 1, 1, 32'h0,          0, 32'h114,       0, 32'h110,       32'h110,      1);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h114,       0, 32'h110,       32'h110,      1);
    // PC wrap at 0xFFFF_FFFC
    cyc(0, 0, 1, 32'hFFFFFFFC,  0, 1, 1, 32'h0,          0, 32'h118,       0, 32'h114,       32'h114,      1);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'hFFFFFFFC,  0, 32'h0,         BB,           0);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h0,         0, 32'hFFFFFFFC,  32'hFFFFFFFC, 1);
    // Branch on miss completion discards the word
    cyc(0, 0, 0, 32'h0,         0, 0, 1, 32'h0,          1, 32'h4,         1, 32'h0,         32'h0,        1);
    cyc(0, 0, 1, 32'h3C,        0, 1, 1, 32'h0,          1, 32'h4,         0, 32'h0,         32'h0,        1);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h3C,        0, 32'h0,         BB,           0);
    // Reset in MISS at 0x40, late ready ignored in BOOT
    cyc(0, 0, 0, 32'h0,         0, 0, 1, 32'h0,          1, 32'h40,        1, 32'h3C,        32'h3C,       1);
    cyc(0, 0, 0, 32'h0,         0, 0, 1, 32'h0,          1, 32'h40,        1, 32'h3C,        32'h3C,       1);
    cyc(1, 0, 0, 32'h0,         0, 0, 1, 32'h0,          0, 32'h40,        0, 32'h3C,        32'h3C,       1);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          0, 32'h0,         0, 32'h0,         BB,           0);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h0,         0, 32'h0,         BB,           0);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h4,         0, 32'h0,         32'h0,        1);
    // Decode stall on miss completion -> HOLD, then release
    cyc(0, 0, 0, 32'h0,         0, 0, 1, 32'h0,          1, 32'h8,         1, 32'h4,         32'h4,        1);
    cyc(0, 1, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'h8,         0, 32'h4,         32'h4,        1);
    cyc(0, 1, 0, 32'h0,         0, 1, 1, 32'h0,          0, 32'h8,         0, 32'h4,         32'h4,        1);
    cyc(0, 0, 0, 32'h0,         0, 0, 1, 32'h0,          0, 32'h8,         0, 32'h4,         32'h4,        1);
    cyc(0, 0, 0, 32'h0,         0, 1, 1, 32'h0,          1, 32'hC,         0, 32'h8,         32'h8,        1);

    @(negedge clock);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending entries, exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
